// File: rtl/gray_pkg.sv
// Shared definitions for the line-local averaging block: the controller state
// encoding and the window constants derived from the half-width radius.
package gray_pkg;

   typedef enum logic [0:0] {
      ST_WAIT_FOR_SOF = 1'b0,
      ST_RUN          = 1'b1
   } state_t;

   localparam int PIXEL_W        = 8;
   localparam int RADIUS_DEFAULT = 8;

   // Number of pixels averaged (must be a power of two).
   function automatic int window_size(input int radius);
      return 2 * radius;
   endfunction

   // Right shift that turns the window sum into the mean.
   function automatic int shift_of(input int radius);
      return $clog2(2 * radius);
   endfunction

   // Width able to hold the sum of a full window of 8-bit pixels.
   function automatic int sum_width(input int radius);
      return PIXEL_W + $clog2(2 * radius);
   endfunction

   localparam int WINDOW_DEFAULT = window_size(RADIUS_DEFAULT);
   localparam int SHIFT_DEFAULT  = shift_of(RADIUS_DEFAULT);
   localparam int SUM_W_DEFAULT  = sum_width(RADIUS_DEFAULT);

endpackage

// File: rtl/pixel_window_shift.sv
// Pixel history for the running window: a shift register that advances on
// every accepted pixel and exposes the oldest stored pixel as its tap.
module pixel_window_shift
   import gray_pkg::*;
#(
   parameter int depth = WINDOW_DEFAULT
) (
   input  logic               clk,
   input  logic               enable,
   input  logic [PIXEL_W-1:0] data,
   output logic [PIXEL_W-1:0] tap
);

   logic [PIXEL_W-1:0] hist_p1 [depth];

   // Shift the newest pixel in at slot 0; history is pure data, never reset
   // because the running sum ignores it until a full window has been refilled.
   always_ff @(posedge clk) begin
      if (enable) begin
         hist_p1[0] <= data;
         for (int i = 1; i < depth; i++) begin
            hist_p1[i] <= hist_p1[i-1];
         end
      end
   end

   assign tap = hist_p1[depth-1];

endmodule

// File: rtl/local_average_line.sv
// Line-local moving average of a gray pixel stream. Frames are delimited by a
// start-of-frame flag in pixel[8]; within each line a running sum over the last
// 2*radius pixels is kept and its truncated mean is emitted once the window is
// full. Windows never cross line boundaries.
module local_average_line
   import gray_pkg::*;
#(
   parameter int radius      = 8,
   parameter int frame_width = 768,
   parameter int frame_lines = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] pixel,
   input  logic       pixel_valid,
   output logic [8:0] pixel_out,
   output logic       pixel_out_valid,
   output logic [7:0] local_average,
   output logic       local_average_valid
);

   localparam int window = window_size(radius);
   localparam int shift  = shift_of(radius);
   localparam int sum_w  = sum_width(radius);
   localparam int col_w  = (frame_width > 1) ? $clog2(frame_width) : 1;
   localparam int line_w = (frame_lines > 1) ? $clog2(frame_lines) : 1;

   localparam logic [col_w-1:0]  col_last   = col_w'(frame_width - 1);
   localparam logic [line_w-1:0] line_last  = line_w'(frame_lines - 1);
   localparam logic [31:0]       win_full   = 32'(window);
   localparam logic [31:0]       win_first  = 32'(window - 1);

   state_t              state, state_next;
   logic [col_w-1:0]    col_cnt, col_next;
   logic [line_w-1:0]   line_cnt, line_next;
   logic [sum_w-1:0]    sum_p1, sum_next;

   logic                sof;
   logic [PIXEL_W-1:0]  gray;
   logic                accept;
   logic [col_w-1:0]    cur_col;
   logic [line_w-1:0]   cur_line;
   logic [PIXEL_W-1:0]  oldest;
   logic                avg_emit;

   assign sof  = pixel[8];
   assign gray = pixel[7:0];

   // An SOF pixel is always accepted and restarts the frame; otherwise pixels
   // only count while a frame is running.
   assign accept   = pixel_valid && (sof || (state == ST_RUN));
   assign cur_col  = sof ? '0 : col_cnt;
   assign cur_line = sof ? '0 : line_cnt;
   assign avg_emit = accept && (32'(cur_col) >= win_first);

   pixel_window_shift #(
      .depth (window)
   ) u_history (
      .clk    (clk),
      .enable (accept),
      .data   (gray),
      .tap    (oldest)
   );

   // Running window sum: restart on column 0, drop the oldest pixel once the
   // window is full. Modular arithmetic in sum_w bits is exact because the
   // final result always fits.
   always_comb begin
      sum_next = sum_p1;
      if (cur_col == '0) begin
         sum_next = sum_w'(gray);
      end else begin
         sum_next = sum_p1 + sum_w'(gray);
         if (32'(cur_col) >= win_full) begin
            sum_next = sum_next - sum_w'(oldest);
         end
      end
   end

   // Next-state and position tracking: advance column/line per accepted pixel
   // and fall back to waiting for SOF after the last pixel of the frame.
   always_comb begin
      state_next = state;
      col_next   = col_cnt;
      line_next  = line_cnt;
      if (accept) begin
         state_next = ST_RUN;
         if (cur_col == col_last) begin
            col_next = '0;
            if (cur_line == line_last) begin
               line_next  = '0;
               state_next = ST_WAIT_FOR_SOF;
            end else begin
               line_next = cur_line + 1'b1;
            end
         end else begin
            col_next  = cur_col + 1'b1;
            line_next = cur_line;
         end
      end
   end

   // Controller state, position counters and window sum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_WAIT_FOR_SOF;
         col_cnt  <= '0;
         line_cnt <= '0;
         sum_p1   <= '0;
      end else begin
         state    <= state_next;
         col_cnt  <= col_next;
         line_cnt <= line_next;
         if (accept) begin
            sum_p1 <= sum_next;
         end
      end
   end

   // Pass-through of the input stream with one cycle of latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_out       <= '0;
         pixel_out_valid <= 1'b0;
      end else begin
         pixel_out       <= pixel;
         pixel_out_valid <= pixel_valid;
      end
   end

   // Mean output: valid for exactly one cycle per full window, value held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         local_average       <= '0;
         local_average_valid <= 1'b0;
      end else begin
         local_average_valid <= avg_emit;
         if (avg_emit) begin
            local_average <= 8'(sum_next >> shift);
         end
      end
   end

endmodule

// File: doc/local_average_line.md
LOCAL_AVERAGE_LINE -- requirements
Module: local_average_line

Interface
REQ-001 SHALL have parameter radius, default 8, window half-width; 2*radius SHALL be a power of two.
REQ-002 SHALL have parameter frame_width, default 768, pixels per line.
REQ-003 SHALL have parameter frame_lines, default 480, lines per frame.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pixel  input  9  bit 8 = start-of-frame (SOF) flag, bits 7:0 = gray value.
REQ-007 SHALL have port pixel_valid  input  1  pixel qualifier, one pixel per asserted cycle.
REQ-008 SHALL have port pixel_out  output  9  registered copy of pixel.
REQ-009 SHALL have port pixel_out_valid  output  1  registered copy of pixel_valid.
REQ-010 SHALL have port local_average  output  8  mean of the last 2*radius pixels of the current line.
REQ-011 SHALL have port local_average_valid  output  1  local_average qualifier.

Function
REQ-012 SHALL register pixel/pixel_valid to pixel_out/pixel_out_valid with exactly 1-cycle latency, in every state.
REQ-013 SHALL implement states ST_WAIT_FOR_SOF and ST_RUN.
REQ-014 ST_WAIT_FOR_SOF -> ST_RUN on pixel_valid with pixel[8]=1; that pixel is column 0, line 0.
REQ-015 In ST_WAIT_FOR_SOF, pixels without SOF SHALL NOT update the window and SHALL NOT produce averages.
REQ-016 SHALL keep a column counter (0..frame_width-1) and a line counter (0..frame_lines-1), advancing only on pixel_valid.
REQ-017 SHALL keep a 12-bit running sum (8 + log2(2*radius) bits) plus a 2*radius-deep pixel history.
REQ-018 Per accepted pixel: sum_next = sum + new - oldest, where oldest is subtracted only once column >= 2*radius.
REQ-019 At column 0, the sum SHALL restart at the new pixel value; windows never span lines.
REQ-020 When the accepted pixel has column >= 2*radius-1, the block SHALL assert local_average_valid one cycle later with local_average = sum_next >> log2(2*radius), truncated.
REQ-021 This yields exactly frame_width-2*radius+1 averages per line (753 at defaults); the first is aligned with pixel_out of column 2*radius-1.
REQ-022 local_average_valid SHALL be low in every cycle not covered by REQ-020; local_average SHALL hold its last value when not valid.
REQ-023 After the pixel at column frame_width-1 of line frame_lines-1, the block SHALL return to ST_WAIT_FOR_SOF.
REQ-024 An SOF pixel received in ST_RUN at any position SHALL resynchronise: that pixel becomes column 0, line 0, the sum restarts, and the partial line emits no further averages.
REQ-025 Gaps in pixel_valid SHALL NOT alter state, sum or counters.

Reset
REQ-026 Reset SHALL drive: state=ST_WAIT_FOR_SOF, counters=0, sum=0, pixel_out=0, pixel_out_valid=0, local_average=0, local_average_valid=0.
REQ-027 Reset asserted mid-line SHALL discard the partial window; the first post-reset average SHALL appear only after the next SOF plus 2*radius pixels.

Structure
REQ-028 The state enum and the derived constants (window size, log2 shift, sum width) SHALL reside in shared package gray_pkg.
REQ-029 The pixel history SHALL be a sub-module pixel_window_shift (parameter depth, 8-bit data, shift-on-enable, tap = oldest).

Verification
REQ-030 Constant frame of value 100: every average = 100; 753 valids per line; 480*753 per frame.
REQ-031 Ramp line with pixel = column mod 256: first average = (0+...+15)>>4 = 7; second = 8.
REQ-032 Window of 15 pixels at 255 and one at 0: sum 3825 -> average 239 (truncation check).
REQ-033 SOF injected at column 300 of line 5: no further averages on the old line; the next average follows 16 pixels later, from new data only.
REQ-034 Reset pulse at column 10, then non-SOF pixels: no averages until SOF; pixel_out still follows the input after 1 cycle.
REQ-035 Random pixel_valid gaps (50% duty) on a random frame: average sequence identical to the gap-free reference model.
